param_mux_scanner: RTL and testbench

//  Parametrised, registered N:1 channel multiplexer with output valid/ready handshake.
//  Two select modes:
//   - manual: a latched select register picks the channel;
//   - scan:   an internal round-robin sequencer visits each channel for DWELL accepted samples.

---
 rtl/param_mux_scanner.sv | 143 ++++++++++++++
 tb/tb_param_mux_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mux_scanner.sv
// param_mux_scanner: registered N:1 channel multiplexer with a valid/ready
// output slot. In manual mode a select pointer loaded by sel_load picks the
// channel. In scan mode the pointer visits channels round-robin, staying on
// each one for DWELL accepted samples.
// Optional feature macro: MUX_PARITY_EN adds dout_par = ^dout, registered with dout.
module param_mux_scanner #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DWELL  = 2,
  parameter int SELW   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SELW-1:0]         sel_in,
  input  logic                    sel_load,
  output logic [WIDTH-1:0]        dout,
  output logic [SELW-1:0]         dout_ch,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    sel_err
`ifdef MUX_PARITY_EN
  ,
  output logic                    dout_par
`endif
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   NUM_CH_W   = (SELW+1)'(NUM_CH);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NUM_CH - 1);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MAN  = 2'd1,
    RUN_SCAN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [WIDTH-1:0] ch_data;
  logic            running;
  logic            slot_free;
  logic            capture;
  logic            sel_ok;
  logic            mode_change;

  assign running     = (state_q != IDLE);
  assign slot_free   = !dout_valid || dout_ready;
  assign capture     = running && slot_free;
  assign sel_ok      = ({1'b0, sel_in} < NUM_CH_W);
  assign mode_change = ((state_q == RUN_MAN)  && (state_d == RUN_SCAN)) ||
                       ((state_q == RUN_SCAN) && (state_d == RUN_MAN));

  // Select the lane currently addressed by the pointer.
  always_comb begin
    ch_data = din[ptr_q*WIDTH +: WIDTH];
  end

  // Next-state logic: en gates running, mode picks manual or scan.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = mode ? RUN_SCAN : RUN_MAN;
      end
      RUN_MAN, RUN_SCAN: begin
        if (!en) state_d = IDLE;
        else     state_d = mode ? RUN_SCAN : RUN_MAN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and dwell counter: scan advance, mode-change clear, sel_load override.
  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    if (capture && (state_q == RUN_SCAN)) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + SELW'(1);
      end else begin
        dwell_d = dwell_q + CW'(1);
      end
    end
    if (mode_change) dwell_d = '0;
    // A valid load wins over any scan advance in the same cycle.
    if (sel_load && sel_ok) begin
      ptr_d   = sel_in;
      dwell_d = '0;
    end
  end

  // State, pointer and dwell registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  // Output slot: capture when free, drop valid on acceptance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
`ifdef MUX_PARITY_EN
      dout_par   <= 1'b0;
`endif
    end else if (capture) begin
      dout       <= ch_data;
      dout_ch    <= ptr_q;
      dout_valid <= 1'b1;
`ifdef MUX_PARITY_EN
      dout_par   <= ^ch_data;
`endif
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky flag for an out-of-range select load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (sel_load && !sel_ok) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_mux_scanner.sv
// Scoreboard bench for param_mux_scanner. Two instances share all controls:
// a 4-channel one and a 3-channel one (the latter exercises out-of-range
// selects and non-power-of-2 wrap). Expected accepted samples are queued per
// instance; negedge monitors pop and compare on every accepted transfer.
module tb_param_mux_scanner;

  localparam int NUM_CH  = 4;
  localparam int NUM_CH3 = 3;
  localparam int WIDTH   = 8;
  localparam int DWELL   = 2;
  localparam int SELW    = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*WIDTH-1:0]  din = '0;
  logic [NUM_CH3*WIDTH-1:0] din3;
  logic                     en = 1'b0;
  logic                     mode = 1'b0;
  logic [SELW-1:0]          sel_in = '0;
  logic                     sel_load = 1'b0;
  logic                     dout_ready = 1'b1;

  logic [WIDTH-1:0] dout, dout3;
  logic [SELW-1:0]  dout_ch, dout_ch3;
  logic             dout_valid, dout_valid3;
  logic             sel_err, sel_err3;
`ifdef MUX_PARITY_EN
  logic             dout_par, dout_par3;
`endif

  logic [WIDTH-1:0] lane [NUM_CH];
  exp_t q4[$];
  exp_t q3[$];
  int n_checks = 0;
  int n_fail   = 0;

  assign din3 = din[NUM_CH3*WIDTH-1:0];

  always #5 clk = ~clk;

  param_mux_scanner #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) u_dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .mode(mode),
    .sel_in(sel_in), .sel_load(sel_load),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .sel_err(sel_err)
`ifdef MUX_PARITY_EN
    , .dout_par(dout_par)
`endif
  );

  param_mux_scanner #(.NUM_CH(NUM_CH3), .WIDTH(WIDTH), .DWELL(DWELL)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .en(en), .mode(mode),
    .sel_in(sel_in), .sel_load(sel_load),
    .dout(dout3), .dout_ch(dout_ch3), .dout_valid(dout_valid3),
    .dout_ready(dout_ready), .sel_err(sel_err3)
`ifdef MUX_PARITY_EN
    , .dout_par(dout_par3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_din();
    for (int k = 0; k < NUM_CH; k++) din[k*WIDTH +: WIDTH] = lane[k];
  endtask

  task automatic random_lanes();
    for (int k = 0; k < NUM_CH; k++) lane[k] = WIDTH'($urandom);
    pack_din();
  endtask

  // Reference model: the k-th accepted sample comes from channel
  // (start + k/DWELL) mod N in scan mode, or always from start in manual mode.
  task automatic push_run(input int n, input int p4, input int p3, input bit scan);
    for (int k = 0; k < n; k++) begin
      int step = scan ? k / DWELL : 0;
      int c4 = (p4 + step) % NUM_CH;
      int c3 = (p3 + step) % NUM_CH3;
      q4.push_back('{data: lane[c4], ch: SELW'(c4)});
      q3.push_back('{data: lane[c3], ch: SELW'(c3)});
    end
  endtask

  // Enters with inputs settled after a rising edge; leaves the same way, out of reset.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; sel_load = 1'b0; dout_ready = 1'b1;
    q4.delete(); q3.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_sel(input int v);
    sel_in = SELW'(v);
    sel_load = 1'b1;
    @(posedge clk); #1;
    sel_load = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int n = 0;
    while ((q4.size() != 0 || q3.size() != 0) && n < budget) begin
      if (rnd) dout_ready = (n >= 6 && n < 11) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    dout_ready = 1'b1;
    check("drain4", 32'(q4.size()), 32'd0);
    check("drain3", 32'(q3.size()), 32'd0);
  endtask

  // Monitor for the 4-channel instance.
  initial begin
    logic stall = 1'b0;
    logic [WIDTH-1:0] pd = '0;
    logic [SELW-1:0]  pc = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall) begin
          check("stall4_valid", 32'(dout_valid), 32'd1);
          check("stall4_data", 32'(dout), 32'(pd));
          check("stall4_ch", 32'(dout_ch), 32'(pc));
        end
        if (dout_valid && dout_ready && q4.size() != 0) begin
          e = q4.pop_front();
          check("data4", 32'(dout), 32'(e.data));
          check("ch4", 32'(dout_ch), 32'(e.ch));
`ifdef MUX_PARITY_EN
          check("par4", 32'(dout_par), 32'(^e.data));
`endif
        end
      end
      stall = !rst && dout_valid && !dout_ready;
      pd = dout;
      pc = dout_ch;
    end
  end

  // Monitor for the 3-channel instance.
  initial begin
    logic stall = 1'b0;
    logic [WIDTH-1:0] pd = '0;
    logic [SELW-1:0]  pc = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall) begin
          check("stall3_valid", 32'(dout_valid3), 32'd1);
          check("stall3_data", 32'(dout3), 32'(pd));
          check("stall3_ch", 32'(dout_ch3), 32'(pc));
        end
        if (dout_valid3 && dout_ready && q3.size() != 0) begin
          e = q3.pop_front();
          check("data3", 32'(dout3), 32'(e.data));
          check("ch3", 32'(dout_ch3), 32'(e.ch));
`ifdef MUX_PARITY_EN
          check("par3", 32'(dout_par3), 32'(^e.data));
`endif
        end
      end
      stall = !rst && dout_valid3 && !dout_ready;
      pd = dout3;
      pc = dout_ch3;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, p3;

    // Reset held two cycles with en=1; first capture afterwards is channel 0.
    random_lanes();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; mode = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ch", 32'(dout_ch), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_err", 32'(sel_err), 32'd0);
    check("rst_valid3", 32'(dout_valid3), 32'd0);
    push_run(6, 0, 0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    wait_drain(100, 1'b1);

    // Manual select of channel 2 with fixed lane data.
    do_reset();
    lane[0] = 8'hAA; lane[1] = 8'hBB; lane[2] = 8'hCC; lane[3] = 8'hDD;
    pack_din();
    load_sel(2);
    push_run(8, 2, 2, 1'b0);
    mode = 1'b0; en = 1'b1;
    wait_drain(100, 1'b0);

    // Out-of-range select on the 3-channel instance: flag set, pointer kept.
    do_reset();
    random_lanes();
    load_sel(2);
    load_sel(3);
    @(negedge clk);
    check("err3_set", 32'(sel_err3), 32'd1);
    check("err4_clear", 32'(sel_err), 32'd0);
    @(posedge clk); #1;
    push_run(8, 3, 2, 1'b0);
    mode = 1'b0; en = 1'b1;
    wait_drain(100, 1'b1);
    check("err3_sticky", 32'(sel_err3), 32'd1);

    // Scan from channel 0 with the consumer always ready: full wrap sequence.
    do_reset();
    random_lanes();
    check("err3_rst", 32'(sel_err3), 32'd0);
    load_sel(0);
    push_run(20, 0, 0, 1'b1);
    mode = 1'b1; en = 1'b1;
    wait_drain(200, 1'b0);

    // Scan from random start channels with random back-pressure and a long stall.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      random_lanes();
      s = $urandom_range(0, NUM_CH - 1);
      p3 = (s < NUM_CH3) ? s : 0;
      load_sel(s);
      push_run(20, s, p3, 1'b1);
      mode = 1'b1; en = 1'b1;
      wait_drain(300, 1'b1);
      check("err3_scan", 32'(sel_err3), 32'(s >= NUM_CH3));
    end

    // Manual mode from random channels with random back-pressure.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      random_lanes();
      s = $urandom_range(0, NUM_CH - 1);
      p3 = (s < NUM_CH3) ? s : 0;
      load_sel(s);
      push_run(10, s, p3, 1'b0);
      mode = 1'b0; en = 1'b1;
      wait_drain(200, 1'b1);
    end

    // en drops while a sample waits: it stays valid until accepted, then nothing new.
    do_reset();
    random_lanes();
    lane[1] = 8'h07;
    pack_din();
    load_sel(1);
    push_run(1, 1, 1, 1'b0);
    dout_ready = 1'b0; mode = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(dout_valid), 32'd1);
      check("hold_data", 32'(dout), 32'h07);
      check("hold_valid3", 32'(dout_valid3), 32'd1);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("idle_valid", 32'(dout_valid), 32'd0);
      check("idle_valid3", 32'(dout_valid3), 32'd0);
    end
    check("drain_hold4", 32'(q4.size()), 32'd0);
    check("drain_hold3", 32'(q3.size()), 32'd0);
    check("err4_final", 32'(sel_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
